// File: rtl/l2_read_arbiter.sv
// Merges I-cache and D-cache L2 read channels onto one L2 read port; owners of
// outstanding bursts are tracked in order. Define L2_RD_ARB_DAT_PRIORITY_EN for fixed DAT priority.
module l2_read_arbiter #(
   parameter int W       = 7,
   parameter int B       = 9,
   parameter int OUT_LOG = 2
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 INS_ADDR_VALID,
   output logic                 INS_ADDR_READY,
   input  logic [29:0]          INS_ADDR,
   output logic                 INS_DATA_VALID,
   input  logic                 INS_DATA_READY,
   output logic [(1<<W)-1:0]    INS_DATA,
   input  logic                 DAT_ADDR_VALID,
   output logic                 DAT_ADDR_READY,
   input  logic [29:0]          DAT_ADDR,
   output logic                 DAT_DATA_VALID,
   input  logic                 DAT_DATA_READY,
   output logic [(1<<W)-1:0]    DAT_DATA,
   output logic                 MEM_ADDR_VALID,
   input  logic                 MEM_ADDR_READY,
   output logic [29:0]          MEM_ADDR,
   input  logic                 MEM_DATA_VALID,
   output logic                 MEM_DATA_READY,
   input  logic [(1<<W)-1:0]    MEM_DATA
);
   localparam int DEPTH    = 1 << OUT_LOG;
   localparam int BW       = B - W;
   localparam int L2_BURST = 1 << BW;

   logic [OUT_LOG:0]   count;
   logic [OUT_LOG-1:0] wr_ptr;
   logic [OUT_LOG-1:0] rd_ptr;
   logic               owner_q [DEPTH];
   logic [BW-1:0]      beat;

   logic slot_free, grant_ok, ins_wins, dat_wins;
   logic grant, grant_dat, nonempty, head, beat_xfer, pop;

   assign slot_free = !MEM_ADDR_VALID | MEM_ADDR_READY;
   // RSTN gating keeps both address READYs low while reset is held
   assign grant_ok  = RSTN & slot_free & (count < (OUT_LOG+1)'(DEPTH));

`ifdef L2_RD_ARB_DAT_PRIORITY_EN
   assign dat_wins = DAT_ADDR_VALID;
   assign ins_wins = INS_ADDR_VALID & !DAT_ADDR_VALID;
`else
   logic last_dat;
   assign ins_wins = INS_ADDR_VALID & (!DAT_ADDR_VALID | last_dat);
   assign dat_wins = DAT_ADDR_VALID & (!INS_ADDR_VALID | !last_dat);
`endif

   assign INS_ADDR_READY = grant_ok & ins_wins;
   assign DAT_ADDR_READY = grant_ok & dat_wins;
   assign grant_dat      = DAT_ADDR_VALID & DAT_ADDR_READY;
   assign grant          = (INS_ADDR_VALID & INS_ADDR_READY) | grant_dat;

   assign nonempty       = (count != '0);
   assign head           = owner_q[rd_ptr];
   assign INS_DATA       = MEM_DATA;
   assign DAT_DATA       = MEM_DATA;
   assign INS_DATA_VALID = MEM_DATA_VALID & nonempty & !head;
   assign DAT_DATA_VALID = MEM_DATA_VALID & nonempty & head;
   assign MEM_DATA_READY = nonempty & (head ? DAT_DATA_READY : INS_DATA_READY);
   assign beat_xfer      = MEM_DATA_VALID & MEM_DATA_READY;
   assign pop            = beat_xfer & (beat == BW'(L2_BURST - 1));

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         MEM_ADDR_VALID <= 1'b0;
         MEM_ADDR       <= '0;
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         beat           <= '0;
      end else begin
         if (grant) begin
            MEM_ADDR_VALID <= 1'b1;
            MEM_ADDR       <= grant_dat ? DAT_ADDR : INS_ADDR;
            wr_ptr         <= wr_ptr + 1'b1;
         end else if (MEM_ADDR_READY) begin
            MEM_ADDR_VALID <= 1'b0;
         end
         if (beat_xfer) beat <= beat + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({grant, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifndef L2_RD_ARB_DAT_PRIORITY_EN
   // Resets to DAT so that INS wins the first tie
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)      last_dat <= 1'b1;
      else if (grant) last_dat <= grant_dat;
   end
`endif

   always_ff @(posedge CLK) begin
      if (grant) owner_q[wr_ptr] <= grant_dat;
   end
endmodule

// File: tb/tb_l2_read_arbiter.sv
// Bench for l2_read_arbiter: cycle-vector table for arbitration plus scoreboarded
// address/beat routing and hand-written stall, empty-FIFO and reset sequences.
module tb_l2_read_arbiter;
   localparam int W = 7, B = 9, OUT_LOG = 2;
   localparam int DW = 1 << W;
`ifdef L2_RD_ARB_DAT_PRIORITY_EN
   localparam bit DATP = 1'b1;
`else
   localparam bit DATP = 1'b0;
`endif

   logic CLK = 1'b0, RSTN = 1'b1;
   logic INS_ADDR_VALID = 0, INS_ADDR_READY, INS_DATA_VALID, INS_DATA_READY = 1;
   logic DAT_ADDR_VALID = 0, DAT_ADDR_READY, DAT_DATA_VALID, DAT_DATA_READY = 1;
   logic MEM_ADDR_VALID, MEM_ADDR_READY = 0, MEM_DATA_VALID = 0, MEM_DATA_READY;
   logic [29:0] INS_ADDR = '0, DAT_ADDR = '0, MEM_ADDR;
   logic [DW-1:0] INS_DATA, DAT_DATA, MEM_DATA = '0;

   l2_read_arbiter #(.W(W), .B(B), .OUT_LOG(OUT_LOG)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .INS_ADDR_VALID(INS_ADDR_VALID), .INS_ADDR_READY(INS_ADDR_READY), .INS_ADDR(INS_ADDR),
      .INS_DATA_VALID(INS_DATA_VALID), .INS_DATA_READY(INS_DATA_READY), .INS_DATA(INS_DATA),
      .DAT_ADDR_VALID(DAT_ADDR_VALID), .DAT_ADDR_READY(DAT_ADDR_READY), .DAT_ADDR(DAT_ADDR),
      .DAT_DATA_VALID(DAT_DATA_VALID), .DAT_DATA_READY(DAT_DATA_READY), .DAT_DATA(DAT_DATA),
      .MEM_ADDR_VALID(MEM_ADDR_VALID), .MEM_ADDR_READY(MEM_ADDR_READY), .MEM_ADDR(MEM_ADDR),
      .MEM_DATA_VALID(MEM_DATA_VALID), .MEM_DATA_READY(MEM_DATA_READY), .MEM_DATA(MEM_DATA)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0, n_err = 0;
   int bi = 0, dat_seen = 0;
   logic [29:0]   exp_addr_q[$];
   logic [29:0]   l2_pend[$];
   logic [DW-1:0] exp_ins_q[$];
   logic [DW-1:0] exp_dat_q[$];

   typedef struct packed {
      logic iv, dv, ir, dr, mav;
   } vec_t;
   vec_t tbl[7];

   function automatic logic [DW-1:0] beat_val(input logic [29:0] a, input int i);
      return {2'b00, a, 32'(i), 2'b11, ~a, 32'(i) + 32'h55};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Transfers are decided by inputs held stable since the previous edge, so the
   // falling edge sees exactly what the next rising edge will accept.
   always @(negedge CLK) begin
      if (RSTN) begin
         if (DAT_DATA_VALID) dat_seen++;
         if (MEM_ADDR_VALID && MEM_ADDR_READY) begin
            if (exp_addr_q.size() == 0) fail_now("mem_addr_unexpected");
            else chk("mem_addr", DW'(MEM_ADDR), DW'(exp_addr_q.pop_front()));
            l2_pend.push_back(MEM_ADDR);
         end
         if (INS_ADDR_VALID && INS_ADDR_READY) begin
            exp_addr_q.push_back(INS_ADDR);
            for (int i = 0; i < 4; i++) exp_ins_q.push_back(beat_val(INS_ADDR, i));
         end
         if (DAT_ADDR_VALID && DAT_ADDR_READY) begin
            exp_addr_q.push_back(DAT_ADDR);
            for (int i = 0; i < 4; i++) exp_dat_q.push_back(beat_val(DAT_ADDR, i));
         end
         if (INS_DATA_VALID && INS_DATA_READY) begin
            if (exp_ins_q.size() == 0) fail_now("ins_beat_unexpected");
            else chk("ins_beat", INS_DATA, exp_ins_q.pop_front());
         end
         if (DAT_DATA_VALID && DAT_DATA_READY) begin
            if (exp_dat_q.size() == 0) fail_now("dat_beat_unexpected");
            else chk("dat_beat", DAT_DATA, exp_dat_q.pop_front());
         end
      end
   end

   task automatic do_reset;
      RSTN = 1'b0;
      INS_ADDR_VALID = 1'b1;
      DAT_ADDR_VALID = 1'b1;
      MEM_DATA_VALID = 1'b1;
      INS_DATA_READY = 1'b1;
      DAT_DATA_READY = 1'b1;
      MEM_ADDR_READY = 1'b0;
      exp_addr_q.delete();
      l2_pend.delete();
      exp_ins_q.delete();
      exp_dat_q.delete();
      bi = 0;
      #1;
      chk("rst_ins_addr_ready", DW'(INS_ADDR_READY), 0);
      chk("rst_dat_addr_ready", DW'(DAT_ADDR_READY), 0);
      chk("rst_mem_addr_valid", DW'(MEM_ADDR_VALID), 0);
      chk("rst_mem_addr", DW'(MEM_ADDR), 0);
      chk("rst_ins_data_valid", DW'(INS_DATA_VALID), 0);
      chk("rst_dat_data_valid", DW'(DAT_DATA_VALID), 0);
      chk("rst_mem_data_ready", DW'(MEM_DATA_READY), 0);
      tick;
      INS_ADDR_VALID = 1'b0;
      DAT_ADDR_VALID = 1'b0;
      MEM_DATA_VALID = 1'b0;
      RSTN = 1'b1;
      tick;
   endtask

   task automatic send_beats(input int n);
      int guard;
      for (int k = 0; k < n; k++) begin
         if (l2_pend.size() == 0) begin
            fail_now("send_beats_no_request");
            MEM_DATA_VALID = 1'b0;
            return;
         end
         MEM_DATA_VALID = 1'b1;
         MEM_DATA = beat_val(l2_pend[0], bi);
         #1;
         guard = 0;
         while (!MEM_DATA_READY && guard < 40) begin
            tick;
            #1;
            guard++;
         end
         if (guard == 40) begin
            fail_now("beat_accept_timeout");
            MEM_DATA_VALID = 1'b0;
            return;
         end
         tick;
         bi++;
         if (bi == 4) begin
            void'(l2_pend.pop_front());
            bi = 0;
         end
      end
      MEM_DATA_VALID = 1'b0;
   endtask

   task automatic issue_ins(input logic [29:0] a);
      int guard;
      INS_ADDR = a;
      INS_ADDR_VALID = 1'b1;
      #1;
      guard = 0;
      while (!INS_ADDR_READY && guard < 40) begin
         tick;
         #1;
         guard++;
      end
      if (guard == 40) fail_now("ins_grant_timeout");
      tick;
      INS_ADDR_VALID = 1'b0;
      tick;
   endtask

   task automatic check_empty(input string tag);
      MEM_DATA_VALID = 1'b1;
      MEM_DATA = {4{32'hDEAD_BEEF}};
      #1;
      chk({tag, "_mem_data_ready"}, DW'(MEM_DATA_READY), 0);
      chk({tag, "_ins_data_valid"}, DW'(INS_DATA_VALID), 0);
      chk({tag, "_dat_data_valid"}, DW'(DAT_DATA_VALID), 0);
      tick;
      #1;
      chk({tag, "_mem_data_ready_hold"}, DW'(MEM_DATA_READY), 0);
      MEM_DATA_VALID = 1'b0;
      tick;
      chk({tag, "_ins_left"}, DW'(exp_ins_q.size()), 0);
      chk({tag, "_dat_left"}, DW'(exp_dat_q.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // iv, dv, exp ins_ready, exp dat_ready, exp MEM_ADDR_VALID
      tbl[0] = DATP ? 5'b11010 : 5'b11100;
      tbl[1] = DATP ? 5'b11011 : 5'b11011;
      tbl[2] = DATP ? 5'b11011 : 5'b11101;
      tbl[3] = DATP ? 5'b11011 : 5'b11011;
      tbl[4] = 5'b11001;
      tbl[5] = 5'b11000;
      tbl[6] = 5'b00000;

      #1;
      do_reset;

      // Single INS request, address held while L2 not ready
      dat_seen = 0;
      INS_ADDR = 30'h0000_0100;
      INS_ADDR_VALID = 1'b1;
      #1;
      chk("t1_ins_ready", DW'(INS_ADDR_READY), 1);
      tick;
      INS_ADDR_VALID = 1'b0;
      #1;
      chk("t1_mem_addr_valid", DW'(MEM_ADDR_VALID), 1);
      chk("t1_mem_addr", DW'(MEM_ADDR), DW'(30'h100));
      tick;
      #1;
      chk("t1_mem_addr_valid_hold", DW'(MEM_ADDR_VALID), 1);
      chk("t1_mem_addr_hold", DW'(MEM_ADDR), DW'(30'h100));
      MEM_ADDR_READY = 1'b1;
      tick;
      #1;
      chk("t1_mem_addr_valid_clear", DW'(MEM_ADDR_VALID), 0);
      send_beats(4);
      chk("t1_dat_valid_seen", DW'(dat_seen), 0);
      check_empty("t1_empty");

      // Arbitration table from reset with L2 address port always ready
      do_reset;
      MEM_ADDR_READY = 1'b1;
      for (int r = 0; r < 7; r++) begin
         INS_ADDR = 30'h1000 + 30'(r);
         DAT_ADDR = 30'h2000 + 30'(r);
         INS_ADDR_VALID = tbl[r].iv;
         DAT_ADDR_VALID = tbl[r].dv;
         #1;
         chk($sformatf("tbl%0d_ins_ready", r), DW'(INS_ADDR_READY), DW'(tbl[r].ir));
         chk($sformatf("tbl%0d_dat_ready", r), DW'(DAT_ADDR_READY), DW'(tbl[r].dr));
         chk($sformatf("tbl%0d_mem_addr_valid", r), DW'(MEM_ADDR_VALID), DW'(tbl[r].mav));
         tick;
      end

      // Full FIFO: no grant until the first burst's last beat has been accepted
      INS_ADDR = 30'h1100;
      DAT_ADDR = 30'h2100;
      INS_ADDR_VALID = 1'b1;
      DAT_ADDR_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         MEM_DATA_VALID = 1'b1;
         MEM_DATA = beat_val(l2_pend.size() > 0 ? l2_pend[0] : 30'h0, bi);
         #1;
         chk($sformatf("full_b%0d_ins_ready", i), DW'(INS_ADDR_READY), 0);
         chk($sformatf("full_b%0d_dat_ready", i), DW'(DAT_ADDR_READY), 0);
         chk($sformatf("full_b%0d_mem_data_ready", i), DW'(MEM_DATA_READY), 1);
         tick;
         bi++;
      end
      if (l2_pend.size() > 0) void'(l2_pend.pop_front());
      bi = 0;
      MEM_DATA_VALID = 1'b0;
      #1;
      chk("after_pop_ins_ready", DW'(INS_ADDR_READY), DW'(!DATP));
      chk("after_pop_dat_ready", DW'(DAT_ADDR_READY), DW'(DATP));
      tick;
      #1;
      chk("refull_ins_ready", DW'(INS_ADDR_READY), 0);
      chk("refull_dat_ready", DW'(DAT_ADDR_READY), 0);
      INS_ADDR_VALID = 1'b0;
      DAT_ADDR_VALID = 1'b0;
      tick;
      send_beats(16);
      check_empty("drain_empty");

      // INS back-pressure mid-burst
      issue_ins(30'h300);
      send_beats(2);
      INS_DATA_READY = 1'b0;
      MEM_DATA_VALID = 1'b1;
      MEM_DATA = beat_val(30'h300, 2);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d_mem_data_ready", c), DW'(MEM_DATA_READY), 0);
         chk($sformatf("stall%0d_ins_data_valid", c), DW'(INS_DATA_VALID), 1);
         chk($sformatf("stall%0d_ins_data", c), INS_DATA, beat_val(30'h300, 2));
         tick;
      end
      INS_DATA_READY = 1'b1;
      send_beats(2);
      check_empty("stall_empty");

      // Reset in the middle of a burst, then a fresh request
      issue_ins(30'h400);
      send_beats(2);
      MEM_DATA_VALID = 1'b1;
      MEM_DATA = beat_val(30'h400, 2);
      do_reset;
      check_empty("postrst_empty");
      MEM_ADDR_READY = 1'b1;
      issue_ins(30'h0000_0200);
      send_beats(4);
      check_empty("fresh_empty");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
